// File: rtl/adxl362_pkg.sv
// Shared constants, FSM encoding and FIFO word formatter for the ADXL362 sample path.
// ADXL362_FIFO_TEMP_EN adds the temperature write state.
package adxl362_pkg;

  localparam logic [1:0] TAG_X = 2'b00;
  localparam logic [1:0] TAG_Y = 2'b01;
  localparam logic [1:0] TAG_Z = 2'b10;
  localparam logic [1:0] TAG_T = 2'b11;

  localparam logic [1:0] FIFO_DISABLED = 2'b00;
  localparam logic [1:0] FIFO_OLDEST   = 2'b01;
  localparam logic [1:0] FIFO_STREAM   = 2'b10;

`ifdef ADXL362_FIFO_TEMP_EN
  typedef enum logic [2:0] {StIdle, StCapture, StWrX, StWrY, StWrZ, StWrT} state_e;
`else
  typedef enum logic [2:0] {StIdle, StCapture, StWrX, StWrY, StWrZ} state_e;
`endif

  function automatic logic [15:0] fmt_word(input logic [1:0] tag, input logic [11:0] data12);
    return {tag, {2{data12[11]}}, data12};
  endfunction

endpackage

// File: rtl/adxl362_sample_fifo.sv
// Single-clock sample FIFO; a full push with stream_discard set overwrites the oldest word.
module adxl362_sample_fifo #(
  parameter int unsigned Depth = 512,
  parameter int unsigned Aw    = 9
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          push,
  input  logic [15:0]   push_data,
  input  logic          pop,
  input  logic          stream_discard,
  input  logic          flush,
  output logic [Aw:0]   entries,
  output logic          full,
  output logic          empty,
  output logic [15:0]   head_data
);

  localparam logic [Aw:0] DepthW = Depth[Aw:0];

  logic [15:0]   mem [Depth];
  logic [Aw-1:0] wptr_q, rptr_q;
  logic [Aw:0]   cnt_q;
  logic          do_pop, do_push, rd_adv;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == DepthW);
  assign entries   = cnt_q;
  assign head_data = empty ? 16'h0000 : mem[rptr_q];

  assign do_pop  = pop & ~empty;
  // A concurrent pop frees the slot the write lands in.
  assign do_push = push & (~full | do_pop | stream_discard);
  assign rd_adv  = do_pop | (push & full & stream_discard);

  always_ff @(posedge clk_sys) begin
    if (rst || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (rd_adv)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !rd_adv)      cnt_q <= cnt_q + 1'b1;
      else if (rd_adv && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wptr_q] <= push_data;
  end

endmodule

// File: rtl/adxl362_sample_sequencer.sv
// Latches X/Y/Z/T on each synchronized ODR rising edge and writes tagged words to the FIFO.
// ADXL362_FIFO_TEMP_EN enables the optional temperature word per sample set.
module adxl362_sample_sequencer
  import adxl362_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned AW         = 9
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          clk_odr,
  input  logic          measure_en,
  input  logic [11:0]   x_in,
  input  logic [11:0]   y_in,
  input  logic [11:0]   z_in,
  input  logic [11:0]   t_in,
  input  logic [1:0]    fifo_mode,
  input  logic          fifo_temp,
  input  logic [AW:0]   fifo_wm,
  input  logic          status_rd,
  input  logic          fifo_rd,
  output logic [11:0]   xdata,
  output logic [11:0]   ydata,
  output logic [11:0]   zdata,
  output logic [11:0]   tdata,
  output logic          data_ready,
  output logic [15:0]   fifo_rd_data,
  output logic [AW:0]   fifo_entries,
  output logic          fifo_watermark,
  output logic          fifo_overrun
);

  localparam logic [AW:0] DepthW = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] N3     = 3;

  state_e      state_q;
  logic        odr_meta_q, odr_sync_q, odr_prev_q, odr_tick;
  logic        push, fifo_full, fifo_empty, stream_mode, space_short;
  logic [15:0] push_data;
  logic [AW:0] n_words;

  assign odr_tick    = odr_sync_q & ~odr_prev_q;
  assign stream_mode = fifo_mode[1];

`ifdef ADXL362_FIFO_TEMP_EN
  localparam logic [AW:0] N4 = 4;
  assign n_words = fifo_temp ? N4 : N3;
`else
  logic unused_fifo_temp;
  assign unused_fifo_temp = fifo_temp;
  assign n_words = N3;
`endif

  assign space_short    = (fifo_entries > (DepthW - n_words));
  assign fifo_watermark = (fifo_wm != '0) && (fifo_entries >= fifo_wm);

  // The latched outputs only change in CAPTURE, so they double as the set buffer.
  always_comb begin
    push      = 1'b0;
    push_data = 16'h0000;
    unique case (state_q)
      StWrX: begin push = 1'b1; push_data = fmt_word(TAG_X, xdata); end
      StWrY: begin push = 1'b1; push_data = fmt_word(TAG_Y, ydata); end
      StWrZ: begin push = 1'b1; push_data = fmt_word(TAG_Z, zdata); end
`ifdef ADXL362_FIFO_TEMP_EN
      StWrT: begin push = 1'b1; push_data = fmt_word(TAG_T, tdata); end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      odr_meta_q   <= 1'b0;
      odr_sync_q   <= 1'b0;
      odr_prev_q   <= 1'b0;
      state_q      <= StIdle;
      xdata        <= '0;
      ydata        <= '0;
      zdata        <= '0;
      tdata        <= '0;
      data_ready   <= 1'b0;
      fifo_overrun <= 1'b0;
    end else begin
      odr_meta_q <= clk_odr;
      odr_sync_q <= odr_meta_q;
      odr_prev_q <= odr_sync_q;

      // Clears come first so any set below in the same cycle wins.
      if (status_rd) begin
        data_ready   <= 1'b0;
        fifo_overrun <= 1'b0;
      end
      if (push && fifo_full && stream_mode) fifo_overrun <= 1'b1;

      unique case (state_q)
        StIdle: if (odr_tick && measure_en) state_q <= StCapture;
        StCapture: begin
          xdata      <= x_in;
          ydata      <= y_in;
          zdata      <= z_in;
          tdata      <= t_in;
          data_ready <= 1'b1;
          if (fifo_mode == FIFO_DISABLED) begin
            state_q <= StIdle;
          end else if (!stream_mode && space_short) begin
            fifo_overrun <= 1'b1;
            state_q      <= StIdle;
          end else begin
            state_q <= StWrX;
          end
        end
        StWrX: state_q <= StWrY;
        StWrY: state_q <= StWrZ;
`ifdef ADXL362_FIFO_TEMP_EN
        StWrZ: state_q <= fifo_temp ? StWrT : StIdle;
        StWrT: state_q <= StIdle;
`else
        StWrZ: state_q <= StIdle;
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  adxl362_sample_fifo #(
    .Depth (FIFO_DEPTH),
    .Aw    (AW)
  ) u_fifo (
    .clk_sys        (clk_sys),
    .rst            (rst),
    .push           (push),
    .push_data      (push_data),
    .pop            (fifo_rd),
    .stream_discard (stream_mode),
    .flush          (fifo_mode == FIFO_DISABLED),
    .entries        (fifo_entries),
    .full           (fifo_full),
    .empty          (fifo_empty),
    .head_data      (fifo_rd_data)
  );

endmodule

// File: tb/tb_adxl362_sample_sequencer.sv
// Directed bench for adxl362_sample_sequencer: capture, FIFO modes, watermark, reset abort.
module tb_adxl362_sample_sequencer;
  import adxl362_pkg::*;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        clk_odr = 1'b0;
  logic        measure_en = 1'b1;
  logic [11:0] x_in = '0, y_in = '0, z_in = '0, t_in = '0;
  logic [1:0]  fifo_mode = 2'b01;
  logic        fifo_temp = 1'b0;
  logic [9:0]  fifo_wm = '0;
  logic        status_rd = 1'b0;
  logic        fifo_rd = 1'b0;
  logic [11:0] xdata, ydata, zdata, tdata;
  logic        data_ready, fifo_watermark, fifo_overrun;
  logic [15:0] fifo_rd_data;
  logic [9:0]  fifo_entries;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  adxl362_sample_sequencer dut (
    .clk_sys        (clk_sys),
    .rst            (rst),
    .clk_odr        (clk_odr),
    .measure_en     (measure_en),
    .x_in           (x_in),
    .y_in           (y_in),
    .z_in           (z_in),
    .t_in           (t_in),
    .fifo_mode      (fifo_mode),
    .fifo_temp      (fifo_temp),
    .fifo_wm        (fifo_wm),
    .status_rd      (status_rd),
    .fifo_rd        (fifo_rd),
    .xdata          (xdata),
    .ydata          (ydata),
    .zdata          (zdata),
    .tdata          (tdata),
    .data_ready     (data_ready),
    .fifo_rd_data   (fifo_rd_data),
    .fifo_entries   (fifo_entries),
    .fifo_watermark (fifo_watermark),
    .fifo_overrun   (fifo_overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic odr_pulse();
    @(negedge clk_sys) clk_odr = 1'b1;
    repeat (12) @(posedge clk_sys);
    @(negedge clk_sys) clk_odr = 1'b0;
    repeat (4) @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic pop_word();
    @(negedge clk_sys) fifo_rd = 1'b1;
    @(negedge clk_sys) fifo_rd = 1'b0;
  endtask

  task automatic status_read();
    @(negedge clk_sys) status_rd = 1'b1;
    @(negedge clk_sys) status_rd = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys) rst = 1'b0;
    check_eq("rst_xdata", 32'(xdata), 32'h0);
    check_eq("rst_ready", 32'(data_ready), 32'h0);
    check_eq("rst_entries", 32'(fifo_entries), 32'h0);
    check_eq("rst_rd_data", 32'(fifo_rd_data), 32'h0);
    check_eq("rst_overrun", 32'(fifo_overrun), 32'h0);

    // Basic three-word set
    x_in = 12'h123; y_in = 12'hF00; z_in = 12'h7FF; t_in = 12'h0A5;
    odr_pulse();
    check_eq("t1_xdata", 32'(xdata), 32'h123);
    check_eq("t1_zdata", 32'(zdata), 32'h7FF);
    check_eq("t1_ready", 32'(data_ready), 32'h1);
    check_eq("t1_entries", 32'(fifo_entries), 32'd3);
    check_eq("t1_word0", 32'(fifo_rd_data), 32'h0123); pop_word();
    check_eq("t1_word1", 32'(fifo_rd_data), 32'h7F00); pop_word();
    check_eq("t1_word2", 32'(fifo_rd_data), 32'h87FF); pop_word();
    check_eq("t1_empty", 32'(fifo_entries), 32'd0);
    status_read();
    check_eq("t1_ready_clr", 32'(data_ready), 32'h0);

    // Temperature word
    fifo_temp = 1'b1;
    odr_pulse();
    check_eq("t2_tdata", 32'(tdata), 32'h0A5);
    check_eq("t2_ready", 32'(data_ready), 32'h1);
`ifdef ADXL362_FIFO_TEMP_EN
    check_eq("t2_entries", 32'(fifo_entries), 32'd4);
`else
    check_eq("t2_entries", 32'(fifo_entries), 32'd3);
`endif
    pop_word(); pop_word();
    check_eq("t2_word2", 32'(fifo_rd_data), 32'h87FF); pop_word();
`ifdef ADXL362_FIFO_TEMP_EN
    check_eq("t2_word3", 32'(fifo_rd_data), 32'hC0A5); pop_word();
`endif
    check_eq("t2_empty", 32'(fifo_entries), 32'd0);
    fifo_temp = 1'b0;

    // Watermark and pop concurrent with a push
    fifo_wm = 10'd6;
    odr_pulse();
    check_eq("wm_below", 32'(fifo_watermark), 32'h0);
    odr_pulse();
    check_eq("wm_entries6", 32'(fifo_entries), 32'd6);
    check_eq("wm_high", 32'(fifo_watermark), 32'h1);
    @(negedge clk_sys) clk_odr = 1'b1;
    repeat (5) @(posedge clk_sys);
    #1;
    check_eq("wm_after_x", 32'(fifo_entries), 32'd7);
    fifo_rd = 1'b1;
    @(posedge clk_sys);
    #1;
    fifo_rd = 1'b0;
    check_eq("wm_rd_with_push", 32'(fifo_entries), 32'd7);
    @(negedge clk_sys) clk_odr = 1'b0;
    repeat (6) @(negedge clk_sys);
    check_eq("wm_entries8", 32'(fifo_entries), 32'd8);
    check_eq("wm_head", 32'(fifo_rd_data), 32'h7F00);
    pop_word(); pop_word();
    check_eq("wm_at6", 32'(fifo_watermark), 32'h1);
    pop_word();
    check_eq("wm_at5", 32'(fifo_watermark), 32'h0);
    @(negedge clk_sys) fifo_mode = 2'b00;
    @(negedge clk_sys);
    check_eq("flush_entries", 32'(fifo_entries), 32'd0);
    fifo_mode = 2'b01;
    status_read();

    // Oldest-saved: fill to 510, then one more set must be dropped whole
    for (int k = 0; k < 170; k++) begin
      x_in = 12'(k); y_in = 12'(12'h200 + k); z_in = 12'(12'h300 + k);
      odr_pulse();
    end
    check_eq("old_fill", 32'(fifo_entries), 32'd510);
    check_eq("old_no_ovr", 32'(fifo_overrun), 32'h0);
    x_in = 12'hAAA; y_in = 12'hBBB; z_in = 12'hCCC;
    odr_pulse();
    check_eq("old_entries", 32'(fifo_entries), 32'd510);
    check_eq("old_overrun", 32'(fifo_overrun), 32'h1);
    check_eq("old_xdata", 32'(xdata), 32'hAAA);
    status_read();
    check_eq("old_ovr_clr", 32'(fifo_overrun), 32'h0);
    check_eq("old_rdy_clr", 32'(data_ready), 32'h0);

    // Stream: 510 + 3 overflows by one, the next set discards three more
    fifo_mode = 2'b10;
    x_in = 12'h400; y_in = 12'h401; z_in = 12'h402;
    odr_pulse();
    check_eq("str_full", 32'(fifo_entries), 32'd512);
    check_eq("str_ovr1", 32'(fifo_overrun), 32'h1);
    check_eq("str_head1", 32'(fifo_rd_data), 32'h4200);
    status_read();
    x_in = 12'h500; y_in = 12'h501; z_in = 12'h502;
    odr_pulse();
    check_eq("str_entries", 32'(fifo_entries), 32'd512);
    check_eq("str_ovr2", 32'(fifo_overrun), 32'h1);
    check_eq("str_head2", 32'(fifo_rd_data), 32'h4201);
    for (int i = 0; i < 511; i++) pop_word();
    check_eq("str_last", 32'(fifo_rd_data), 32'h8502);
    pop_word();
    check_eq("str_drained", 32'(fifo_entries), 32'd0);
    check_eq("str_rd_empty", 32'(fifo_rd_data), 32'h0);

    // Reset in the middle of a set
    @(negedge clk_sys) clk_odr = 1'b1;
    repeat (5) @(posedge clk_sys);
    #1;
    check_eq("rst_mid_x_pushed", 32'(fifo_entries), 32'd1);
    rst = 1'b1;
    clk_odr = 1'b0;
    @(posedge clk_sys);
    #1;
    rst = 1'b0;
    check_eq("rst_mid_entries", 32'(fifo_entries), 32'd0);
    check_eq("rst_mid_ready", 32'(data_ready), 32'h0);
    check_eq("rst_mid_xdata", 32'(xdata), 32'h0);
    check_eq("rst_mid_ovr", 32'(fifo_overrun), 32'h0);
    check_eq("rst_mid_state", 32'(dut.state_q), 32'(StIdle));
    repeat (8) @(negedge clk_sys);
    check_eq("rst_mid_quiet", 32'(fifo_entries), 32'd0);

    // Measurement disabled: ODR edges ignored
    measure_en = 1'b0;
    x_in = 12'h321;
    odr_pulse();
    check_eq("meas_off_ready", 32'(data_ready), 32'h0);
    check_eq("meas_off_xdata", 32'(xdata), 32'h0);
    check_eq("meas_off_entries", 32'(fifo_entries), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adxl362_sample_sequencer.md
Name: adxl362_sample_sequencer

Overview:
- Consumes the selected output-data-rate clock (clk_odr) from the ADXL362 system controller in the behavioral accelerometer model.
- On each ODR rising edge it latches X/Y/Z/temperature samples and raises data-ready.
- It also pushes axis-tagged words into the model's sample FIFO, which the SPI register front-end drains.
- All logic runs in the clk_sys domain; clk_odr is treated as asynchronous.

Parameters:
- FIFO_DEPTH, 512, FIFO capacity in 16-bit words (power of two).
- AW, 9, FIFO address width; equals log2(FIFO_DEPTH).

Ports:
- clk_sys  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- clk_odr  in  1  ODR clock, asynchronous to clk_sys.
- measure_en  in  1  measurement mode; when low, ODR edges are ignored.
- x_in, y_in, z_in, t_in  in  12 each  live sensor values, two's complement.
- fifo_mode  in  2  00 disabled, 01 oldest-saved, 10 stream, 11 treated as 10.
- fifo_temp  in  1  also store a temperature word per sample set.
- fifo_wm  in  AW+1  watermark level, in words.
- status_rd  in  1  one-cycle pulse; clears data_ready and fifo_overrun.
- fifo_rd  in  1  one-cycle pop request.
- xdata, ydata, zdata, tdata  out  12 each  latched samples.
- data_ready  out  1  new sample set latched.
- fifo_rd_data  out  16  FIFO head word.
- fifo_entries  out  AW+1  current word count.
- fifo_watermark  out  1  high when fifo_entries >= fifo_wm and fifo_wm != 0.
- fifo_overrun  out  1  sticky overrun flag.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk_sys.
  - All outputs reset to 0; the FIFO is emptied; pointers go to 0; the FSM goes to IDLE.
  - The synchronizer flops reset to 0.
  - rst mid-set aborts the set; no partial words survive.
- ODR synchronizer and edge detect:
  - clk_odr passes through a 2-flop synchronizer, then a rising-edge detect producing odr_tick.
  - odr_tick asserts 3 clk_sys cycles after a clk_odr rise, worst case.
- FIFO word format: [15:14] tag (00 X, 01 Y, 10 Z, 11 T), [13:12] sign extension of bit 11, [11:0] data.
- FSM states: IDLE, CAPTURE, WR_X, WR_Y, WR_Z, WR_T.
  - IDLE -> CAPTURE on odr_tick & measure_en.
  - CAPTURE:
    - Latch x/y/z/t_in into xdata/ydata/zdata/tdata and into an internal set buffer.
    - data_ready goes high on the next cycle.
    - Compute words-per-set, N = 4 if fifo_temp else 3.
    - Next state: fifo_mode==00 -> IDLE.
    - Next state: fifo_mode==01 and free space < N -> IDLE; set fifo_overrun; the whole set is dropped (atomic).
    - Otherwise -> WR_X.
  - WR_X -> WR_Y -> WR_Z: one push per cycle.
  - WR_Z -> WR_T if fifo_temp, else -> IDLE.
  - WR_T -> IDLE.
  - The set is written from the buffer, so input changes during the WR states are ignored.
  - odr_tick arriving outside IDLE is dropped; at least 6 cycles separate ticks in practice.
  - measure_en falling mid-set: the set completes.
- Stream mode (10):
  - A push while full discards the oldest word (read pointer advances) and sets fifo_overrun.
  - Entries stay at FIFO_DEPTH.
- FIFO read:
  - fifo_rd_data shows the head word combinationally from the read pointer; it is 0 when empty.
  - fifo_rd while empty: no effect.
  - fifo_rd concurrent with a push: entries unchanged, both pointers advance.
  - fifo_rd concurrent with a stream-mode full discard: the read pointer advances once.
- Pointers wrap modulo FIFO_DEPTH; entries is tracked as a counter, 0..FIFO_DEPTH.
- fifo_mode change to 00: the FIFO is flushed (entries=0) on the next cycle.
- data_ready:
  - Set has priority over status_rd in the same cycle.
  - fifo_overrun follows the same rule: set wins over clear.

Optional Feature:
- ADXL362_FIFO_TEMP_EN defined: the WR_T state exists and fifo_temp is honoured.
- Not defined: fifo_temp is ignored and treated as 0; N=3; WR_T is removed; tdata is still latched at CAPTURE.

Decomposition:
- Package adxl362_pkg holds:
  - tag constants TAG_X/Y/Z/T;
  - FIFO mode constants FIFO_DISABLED/OLDEST/STREAM;
  - FSM state encoding;
  - helper function fmt_word(tag, data12).
- Sub-module adxl362_sample_fifo: sync single-clock FIFO with push, pop, stream_discard, flush, entries, full, empty, head data.
- Synchronizer, edge detect and FSM stay in the top module.

Test Plan:
- Reset, then clk_odr toggled with measure_en=1, fifo_mode=01, fifo_temp=0, x/y/z = 12'h123 / 12'hF00 / 12'h7FF.
  - Expect xdata=12'h123 and data_ready=1.
  - Expect FIFO words 16'h0123, 16'h7F00, 16'h87FF; fifo_entries=3.
- Same with fifo_temp=1 and t_in=12'h0A5, under ADXL362_FIFO_TEMP_EN.
  - Expect a 4th word 16'hC0A5; fifo_entries=4.
  - Without the macro: fifo_entries=3.
- Oldest-saved mode, pre-filled to 510 words, fifo_temp=0, one ODR tick.
  - Set dropped; fifo_entries stays 510; fifo_overrun=1.
  - status_rd clears overrun and data_ready.
- Stream mode, full FIFO, one tick.
  - fifo_entries stays 512; fifo_overrun=1; head advances by 3 words; last word read equals the newest Z.
- fifo_wm=6, two ticks (6 words): fifo_watermark=1.
  - fifo_rd concurrent with the WR_Y push leaves the count unchanged.
  - Popping to 5 drops the watermark.
- rst asserted during WR_Y: next cycle all outputs are 0, fifo_entries=0, FSM is IDLE.
  - measure_en=0 with an ODR toggle: data_ready remains 0.
